// File: rtl/envase_pkg.sv
// Shared types and constants for the bottling-line sequencer.
package envase_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MOVE  = 3'd1,
        FILL  = 3'd2,
        CAP   = 3'd3,
        EXIT  = 3'd4,
        FAULT = 3'd5
    } state_t;

    localparam int BOX_SIZE = 12;

endpackage

// File: rtl/envase_timer.sv
// Shared state timer: synchronous clear, count enable, compare against a runtime terminal value.
module envase_timer #(
    parameter int W = 9
) (
    input  logic         CLOCK,
    input  logic         RESET,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] term_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)     cnt_d = '0;
        else if (en_i) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == term_i);

endmodule

// File: rtl/controle_envase.sv
// Bottling-line sequencer: conveyor, fill valve, corker, bottle count and fault flag.
// Optional box-full pulse output is built when CONTA_CAIXA_EN is defined.
module controle_envase
    import envase_pkg::*;
#(
    parameter int MOVE_TIMEOUT = 200,
    parameter int FILL_TIMEOUT = 500,
    parameter int CAP_CYCLES   = 8,
    parameter int COUNT_W      = 8
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               START,
    input  logic               STOP,
    input  logic               RECONHECE,
    input  logic               SENSOR_GARRAFA,
    input  logic               SENSOR_NIVEL,
    output logic               MOTOR,
    output logic               VALVULA,
    output logic               ROLHADOR,
    output logic               ALARME,
    output logic               OCUPADO,
`ifdef CONTA_CAIXA_EN
    output logic               CAIXA_CHEIA,
`endif
    output logic [COUNT_W-1:0] CONTAGEM
);

    localparam int TMAX_A = (MOVE_TIMEOUT > FILL_TIMEOUT) ? MOVE_TIMEOUT : FILL_TIMEOUT;
    localparam int TMAX   = (TMAX_A > CAP_CYCLES) ? TMAX_A : CAP_CYCLES;
    localparam int TW     = $clog2(TMAX + 1);

    state_t             state_q, state_d;
    logic               stop_q, stop_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               inc;
    logic               stop_any;
    logic               tmr_clr, tmr_en, tmr_done;
    logic [TW-1:0]      tmr_term;

    assign stop_any = stop_q | STOP;

    // Terminal value depends on which state owns the timer right now
    always_comb begin
        tmr_term = '0;
        tmr_en   = 1'b0;
        case (state_q)
            MOVE: begin tmr_term = TW'(MOVE_TIMEOUT - 1); tmr_en = 1'b1; end
            FILL: begin tmr_term = TW'(FILL_TIMEOUT - 1); tmr_en = 1'b1; end
            CAP:  begin tmr_term = TW'(CAP_CYCLES - 1);   tmr_en = 1'b1; end
            default: ;
        endcase
    end

    assign tmr_clr = (state_d != state_q);

    envase_timer #(.W(TW)) u_timer (
        .CLOCK  (CLOCK),
        .RESET  (RESET),
        .clr_i  (tmr_clr),
        .en_i   (tmr_en),
        .term_i (tmr_term),
        .done_o (tmr_done)
    );

    always_comb begin
        state_d = state_q;
        stop_d  = stop_q;
        inc     = 1'b0;
        case (state_q)
            IDLE: begin
                stop_d = 1'b0;
                if (START && !STOP) state_d = MOVE;
            end
            MOVE: begin
                if (STOP) stop_d = 1'b1;
                if (SENSOR_GARRAFA) state_d = FILL;
                else if (stop_any)  state_d = IDLE;
                else if (tmr_done)  state_d = IDLE;
            end
            FILL: begin
                if (STOP) stop_d = 1'b1;
                if (SENSOR_NIVEL)  state_d = CAP;
                else if (tmr_done) state_d = FAULT;
            end
            CAP: begin
                if (STOP) stop_d = 1'b1;
                if (tmr_done) state_d = EXIT;
            end
            EXIT: begin
                if (STOP) stop_d = 1'b1;
                if (!SENSOR_GARRAFA) begin
                    inc     = 1'b1;
                    state_d = stop_any ? IDLE : MOVE;
                end
            end
            FAULT: begin
                if (RECONHECE) state_d = IDLE;
            end
            default: state_d = FAULT;
        endcase
        cnt_d = cnt_q + COUNT_W'(inc);
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= IDLE;
            stop_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            stop_q  <= stop_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore decode; unknown encodings look like a fault until they get there
    always_comb begin
        MOTOR    = 1'b0;
        VALVULA  = 1'b0;
        ROLHADOR = 1'b0;
        ALARME   = 1'b0;
        OCUPADO  = 1'b0;
        case (state_q)
            IDLE:  ;
            MOVE:  begin MOTOR    = 1'b1; OCUPADO = 1'b1; end
            FILL:  begin VALVULA  = 1'b1; OCUPADO = 1'b1; end
            CAP:   begin ROLHADOR = 1'b1; OCUPADO = 1'b1; end
            EXIT:  begin MOTOR    = 1'b1; OCUPADO = 1'b1; end
            default: ALARME = 1'b1;
        endcase
    end

    assign CONTAGEM = cnt_q;

`ifdef CONTA_CAIXA_EN
    localparam int BOX_W = $clog2(BOX_SIZE);

    logic [BOX_W-1:0] box_q;
    logic             caixa_q;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            box_q   <= '0;
            caixa_q <= 1'b0;
        end else begin
            caixa_q <= 1'b0;
            if (inc) begin
                if (box_q == BOX_W'(BOX_SIZE - 1)) begin
                    box_q   <= '0;
                    caixa_q <= 1'b1;
                end else begin
                    box_q <= box_q + 1'b1;
                end
            end
        end
    end

    assign CAIXA_CHEIA = caixa_q;
`endif

endmodule
